mips_mc_core: RTL and testbench
===============================

# mips_mc_core

Parametrised multi-cycle MIPS-I subset core: register file, ALU, immediate extender, next-PC logic and a control FSM behind a single shared instruction/data memory port with a ready handshake. It is the next-generation CPU top. The previous one assumed zero-wait, split instruction and data memories and had no halt. This core tolerates wait states, has a configurable reset vector and address width, retires an instruction counter, and halts on illegal opcodes.

## Interface
- `AW`, 10: memory word-address width. Byte addressable space is 2^(AW+2).
- `RESET_PC`, 32'h0000_3000: PC loaded on reset. Must be word aligned.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `mem_req`  out  1: memory transfer request.
- `mem_we`  out  1: 1 = write (sw), 0 = read.
- `mem_addr`  out  AW: word address, equal to byte address bits [AW+1:2].
- `mem_wdata`  out  32: store data.
- `mem_rdata`  in  32: read data, valid in the cycle `mem_ready`=1.
- `mem_ready`  in  1: transfer completes in the cycle it is high while `mem_req`=1.
- `halted`  out  1: core stopped on an illegal instruction.
- `instret`  out  32: retired-instruction count.
- `pc_o`  out  32: current PC, for debug.

## Operation
- Supported instructions:
  - R-type (op 0) funct: addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2A, jr 0x08.
  - I-type op: addiu 0x09, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04.
  - J-type op: j 0x02, jal 0x03.
  - Any other op/funct is illegal.
- Extension: ori zero-extends; addiu, lw, sw and beq sign-extend. lui places imm in [31:16] with zeros below. slt is a signed compare. All other arithmetic wraps modulo 2^32 with no overflow trap.
- Register file: 32x32, two combinational reads, one synchronous write. Writes to $0 are dropped; $0 always reads 0.
- FSM states:
  - `IDLE` → `FETCH` unconditionally.
  - `FETCH`: `mem_req`=1, `mem_we`=0, `mem_addr`=PC. On `mem_ready`, latch IR and set PC←PC+4; go to `DECODE`. Otherwise stay.
  - `DECODE`: latch A←rs and B←rt. Compute the branch target PC+4+(sext(imm)<<2) into ALUOUT. An illegal instruction goes to `HALT`; otherwise go to `EXEC`.
  - `EXEC`:
    - R/I ALU ops: ALUOUT←result, go to `WB`.
    - lw/sw: ALUOUT←A+sext(imm), go to `MEM`.
    - beq: if A==B then PC←target; retire; go to `FETCH`.
    - j: PC←{PC[31:28], idx, 2'b00}; retire.
    - jal: as j, plus $31←PC (already PC+4); retire.
    - jr: PC←A; retire.
  - `MEM`: `mem_req`=1 and `mem_addr`=ALUOUT[AW+1:2].
    - sw: `mem_we`=1, `mem_wdata`=B. On ready, retire and go to `FETCH`.
    - lw: on ready, latch MDR and go to `WB`.
  - `WB`: write rd (R-type), rt (I-type ALU) or MDR (lw). Retire; go to `FETCH`.
  - `HALT`: terminal. `halted`=1, `mem_req`=0. Only reset leaves it.
- Retire means `instret`←`instret`+1 on that edge, wrapping at 2^32.
- Misaligned addresses are not checked; bits [1:0] are ignored.

## Timing
- Reset values: state `IDLE`, PC=`RESET_PC`, `mem_req`=0, `mem_we`=0, `mem_wdata`=0, `halted`=0, `instret`=0. IR, A, B, ALUOUT and MDR are all 0. The register file is not reset.
- While in `IDLE`, `mem_addr`=`RESET_PC`[AW+1:2].
- Zero-wait latency in cycles:
  - R-type and I-type ALU: 4.
  - lw: 5.
  - sw: 4.
  - beq, j, jal, jr: 3.
- Each wait cycle (`mem_ready`=0 while requesting) adds one cycle.
- Handshake: while `mem_req`=1, `mem_we`, `mem_addr` and `mem_wdata` are held stable until the ready cycle. `mem_req` deasserts the cycle after the ready cycle, except where FETCH follows directly after retire. Then `mem_req` stays high with the new address.
- `mem_ready` outside a request is ignored.
- Reset assertion mid-transfer aborts it immediately: no register-file or memory side effects after the reset edge.
- `halted` rises the cycle after `DECODE` of the illegal instruction. `instret` does not count it.

## Structure
- Package `mips_mc_pkg` holds:
  - opcode and funct localparams;
  - the state enum {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT};
  - the ALU-op enum {ADD, SUB, AND, OR, SLT, LUI}.
- One natural sub-module: `mips_mc_alu`, purely combinational (a, b, op → y, eq).
- The FSM, register file and datapath registers live in the top module.

## Test plan
- Reset with `RESET_PC`=0, `rst` released: one `IDLE` cycle with `mem_req`=0, then `FETCH` with `mem_addr`=0 and `mem_req`=1.
- Zero-wait program: ori $1,$0,5; ori $2,$0,7; addu $3,$1,$2; sw $3,0x100($0). Required: a write of 32'd12 at word address 0x40 on cycle 17 after `IDLE`, and `instret`=4 afterwards.
- Wait states: `mem_ready` held low 3 cycles in the lw `MEM` phase. Required: `mem_addr` stable throughout, MDR equal to `mem_rdata` from the ready cycle, lw total 8 cycles.
- Control flow: beq $0,$0,+1 at 0x0 → next fetch at 0x8. jal at 0x8 to idx 0x10 → $31=0xC and fetch at 0x40. jr $31 → fetch at 0xC.
- Signed and edge cases:
  - addiu $1,$0,-1; slt $2,$1,$0 → $2=1.
  - lui $3,0x8000 → $3=0x8000_0000.
  - addu to $0 → $0 stays 0.
- Illegal op 0x3F at 0x4: `halted`=1, `mem_req`=0 indefinitely, `instret` frozen. A `rst` low pulse mid-HALT or mid-MEM restarts from `RESET_PC`.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared opcodes, FSM states and ALU operations for the multi-cycle MIPS core.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    SLT = 3'd4,
    LUI = 3'd5
  } alu_op_t;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADDU) || (fn == FN_SUBU) || (fn == FN_AND) ||
                     (fn == FN_OR) || (fn == FN_SLT) || (fn == FN_JR);
      OP_J, OP_JAL, OP_BEQ, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_mc_alu.sv
// Combinational ALU; eq is the raw a==b compare used by beq.
module mips_mc_alu
  import mips_mc_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [2:0]  i_op,
  output logic [31:0] o_y,
  output logic        o_eq
);

  always_comb begin
    o_y = 32'h0;
    case (i_op)
      ADD:     o_y = i_a + i_b;
      SUB:     o_y = i_a - i_b;
      AND:     o_y = i_a & i_b;
      OR:      o_y = i_a | i_b;
      SLT:     o_y = {31'h0, $signed(i_a) < $signed(i_b)};
      LUI:     o_y = {i_b[15:0], 16'h0};
      default: o_y = 32'h0;
    endcase
  end

  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS-I subset core on one shared memory port with a ready handshake.
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready,
  output logic          halted,
  output logic [31:0]   instret,
  output logic [31:0]   pc_o,
  output logic [2:0]    dbg_state
);

  // Memory handshake: address/we/wdata are held while req is high and ready is low;
  // a transfer completes on the rising edge where req and ready are both high.
  state_t        r_state;
  logic [31:0]   r_pc, r_ir, r_a, r_b, r_aluout, r_mdr, r_instret, r_mem_wdata;
  logic          r_halted, r_mem_req, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [31:0]   r_rf [32];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_sext, w_zext, w_rs_val, w_rt_val, w_br_target, w_jump_pc;
  logic        w_is_r, w_is_ctl, w_is_mem, w_legal;
  alu_op_t     w_alu_op;
  logic [31:0] w_alu_b, w_alu_y;
  logic        w_alu_eq;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_funct  = r_ir[5:0];
  assign w_sext   = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_zext   = {16'h0, r_ir[15:0]};
  assign w_is_r   = (w_op == OP_RTYPE);
  assign w_is_ctl = (w_op == OP_BEQ) || (w_op == OP_J) || (w_op == OP_JAL) ||
                    (w_is_r && w_funct == FN_JR);
  assign w_is_mem = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_legal  = is_legal(w_op, w_funct);

  assign w_rs_val    = (w_rs == 5'd0) ? 32'h0 : r_rf[w_rs];
  assign w_rt_val    = (w_rt == 5'd0) ? 32'h0 : r_rf[w_rt];
  assign w_br_target = r_pc + {w_sext[29:0], 2'b00};

  always_comb begin
    w_alu_op = ADD;
    w_alu_b  = w_sext;
    if (w_is_r) begin
      w_alu_b = r_b;
      case (w_funct)
        FN_SUBU: w_alu_op = SUB;
        FN_AND:  w_alu_op = AND;
        FN_OR:   w_alu_op = OR;
        FN_SLT:  w_alu_op = SLT;
        default: w_alu_op = ADD;
      endcase
    end else begin
      case (w_op)
        OP_ORI:  begin w_alu_op = OR;  w_alu_b = w_zext; end
        OP_LUI:  begin w_alu_op = LUI; w_alu_b = w_zext; end
        OP_BEQ:  begin w_alu_op = SUB; w_alu_b = r_b;    end
        default: begin w_alu_op = ADD; w_alu_b = w_sext; end
      endcase
    end
  end

  mips_mc_alu u_alu (
    .i_a  (r_a),
    .i_b  (w_alu_b),
    .i_op (w_alu_op),
    .o_y  (w_alu_y),
    .o_eq (w_alu_eq)
  );

  // r_pc already holds PC+4 here; r_aluout holds the branch target from DECODE.
  always_comb begin
    case (w_op)
      OP_BEQ:      w_jump_pc = w_alu_eq ? r_aluout : r_pc;
      OP_J, OP_JAL: w_jump_pc = {r_pc[31:28], r_ir[25:0], 2'b00};
      default:     w_jump_pc = r_a;
    endcase
  end

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rt;
    w_rf_wdata = r_aluout;
    if (r_state == EXEC && w_op == OP_JAL) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = 5'd31;
      w_rf_wdata = r_pc;
    end else if (r_state == WB) begin
      w_rf_we = 1'b1;
      if (w_is_r) w_rf_waddr = w_rd;
      if (w_op == OP_LW) w_rf_wdata = r_mdr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rf_we && w_rf_waddr != 5'd0) r_rf[w_rf_waddr] <= w_rf_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_ir        <= 32'h0;
      r_a         <= 32'h0;
      r_b         <= 32'h0;
      r_aluout    <= 32'h0;
      r_mdr       <= 32'h0;
      r_instret   <= 32'h0;
      r_halted    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= RESET_PC[AW+1:2];
      r_mem_wdata <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FETCH;
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_pc[AW+1:2];
        end
        FETCH: if (mem_ready) begin
          r_ir      <= mem_rdata;
          r_pc      <= r_pc + 32'd4;
          r_mem_req <= 1'b0;
          r_state   <= DECODE;
        end
        DECODE: begin
          r_a      <= w_rs_val;
          r_b      <= w_rt_val;
          r_aluout <= w_br_target;
          if (w_legal) r_state <= EXEC;
          else begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end
        end
        EXEC: begin
          if (w_is_ctl) begin
            r_pc       <= w_jump_pc;
            r_instret  <= r_instret + 32'd1;
            r_state    <= FETCH;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_jump_pc[AW+1:2];
          end else if (w_is_mem) begin
            r_aluout    <= w_alu_y;
            r_state     <= MEM;
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_op == OP_SW);
            r_mem_addr  <= w_alu_y[AW+1:2];
            r_mem_wdata <= r_b;
          end else begin
            r_aluout <= w_alu_y;
            r_state  <= WB;
          end
        end
        MEM: if (mem_ready) begin
          r_mem_we <= 1'b0;
          if (w_op == OP_SW) begin
            r_instret  <= r_instret + 32'd1;
            r_state    <= FETCH;
            r_mem_addr <= r_pc[AW+1:2];
          end else begin
            r_mdr     <= mem_rdata;
            r_mem_req <= 1'b0;
            r_state   <= WB;
          end
        end
        WB: begin
          r_instret  <= r_instret + 32'd1;
          r_state    <= FETCH;
          r_mem_req  <= 1'b1;
          r_mem_addr <= r_pc[AW+1:2];
        end
        HALT:    r_mem_req <= 1'b0;
        default: r_state   <= IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign halted    = r_halted;
  assign instret   = r_instret;
  assign pc_o      = r_pc;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed programs against mips_mc_core with a wait-state capable memory model.
module tb_mips_mc_core;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic          mem_ready = 1'b0;
  logic          halted;
  logic [31:0]   instret, pc_o;
  logic [2:0]    dbg_state;

  mips_mc_core #(.AW(AW), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .instret   (instret),
    .pc_o      (pc_o),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) if (rst) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mem [1024];
  logic [63:0] exp_q[$];
  logic [63:0] wr_q[$];
  int          wr_cyc_q[$];
  logic [31:0] rd_addr_q[$];
  int          rd_cyc_q[$];

  logic [AW-1:0] wait_addr = '0;
  int            wait_n = 0;
  int            wait_cnt = 0;
  logic          hold_we = 1'b0;
  logic [31:0]   hold_wdata = 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- memory driver ----------------
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    if (!rst) begin
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt > 0) begin
        check("hold_addr", 64'(mem_addr), 64'(wait_addr));
        check("hold_we", 64'(mem_we), 64'(hold_we));
        check("hold_wdata", 64'(mem_wdata), 64'(hold_wdata));
      end
      if ((wait_cnt > 0 || mem_addr == wait_addr) && wait_cnt < wait_n) begin
        if (wait_cnt == 0) begin
          hold_we    = mem_we;
          hold_wdata = mem_wdata;
        end
        wait_cnt++;
      end else begin
        mem_ready = 1'b1;
        if (wait_cnt > 0) wait_n = 0;
        wait_cnt = 0;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wr_q.push_back({32'(mem_addr), mem_wdata});
          wr_cyc_q.push_back(cyc);
        end else begin
          mem_rdata = mem[mem_addr];
          rd_addr_q.push_back(32'(mem_addr));
          rd_cyc_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic begin_test();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    exp_q.delete();
    wr_q.delete();
    wr_cyc_q.delete();
    rd_addr_q.delete();
    rd_cyc_q.delete();
  endtask

  task automatic put(input int byte_addr, input logic [31:0] w);
    mem[byte_addr >> 2] = w;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    cyc = 1;
  endtask

  task automatic run_to_halt(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("halt_reached", 64'(halted), 64'd1);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check({tag, "_wr"}, wr_q[i], exp_q[i]);
  endtask

  task automatic check_read(input string tag, input int idx, input logic [31:0] addr, input int c);
    if (idx < rd_addr_q.size()) begin
      check({tag, "_rd_addr"}, 64'(rd_addr_q[idx]), 64'(addr));
      check({tag, "_rd_cyc"}, 64'(rd_cyc_q[idx]), 64'(c));
    end else begin
      check({tag, "_rd_missing"}, 64'(rd_addr_q.size()), 64'(idx + 1));
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Reset values and the single IDLE cycle
    begin_test();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_instret", 64'(instret), 64'd0);
    check("rst_pc", 64'(pc_o), 64'd0);
    release_rst();
    #1;
    check("idle_state", 64'(dbg_state), 64'd0);
    check("idle_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    #1;
    check("fetch_state", 64'(dbg_state), 64'd1);
    check("fetch_req", 64'(mem_req), 64'd1);
    check("fetch_addr", 64'(mem_addr), 64'd0);
    run_to_halt(50);
    check("nop_instret", 64'(instret), 64'd0);

    // Zero-wait program ending in a store of 12 to word 0x40
    begin_test();
    put(32'h00, 32'h3401_0005);
    put(32'h04, 32'h3402_0007);
    put(32'h08, 32'h0022_1821);
    put(32'h0C, 32'hAC03_0100);
    put(32'h10, 32'hFC00_0000);
    exp_q.push_back({32'h40, 32'd12});
    release_rst();
    run_to_halt(100);
    check_writes("zw");
    if (wr_cyc_q.size() > 0) check("zw_wr_cyc", 64'(wr_cyc_q[0]), 64'd17);
    check("zw_instret", 64'(instret), 64'd4);
    check("zw_halt_req", 64'(mem_req), 64'd0);

    // lw with 3 wait states on its data phase
    begin_test();
    put(32'h000, 32'h8C01_0200);
    put(32'h004, 32'hAC01_0204);
    put(32'h008, 32'hFC00_0000);
    put(32'h200, 32'hDEAD_BEEF);
    wait_addr = 10'h080;
    wait_n    = 3;
    exp_q.push_back({32'h81, 32'hDEAD_BEEF});
    release_rst();
    run_to_halt(100);
    check_writes("lw");
    check_read("lw", 0, 32'h00, 2);
    check_read("lw", 1, 32'h80, 8);
    check_read("lw", 2, 32'h01, 10);
    check_read("lw", 3, 32'h02, 14);
    if (wr_cyc_q.size() > 0) check("lw_wr_cyc", 64'(wr_cyc_q[0]), 64'd13);
    check("lw_instret", 64'(instret), 64'd2);

    // beq taken, jal, jr back, store $31
    begin_test();
    put(32'h00, 32'h1000_0001);
    put(32'h04, 32'hFC00_0000);
    put(32'h08, 32'h0C00_0010);
    put(32'h0C, 32'hAC1F_0300);
    put(32'h10, 32'hFC00_0000);
    put(32'h40, 32'h03E0_0008);
    exp_q.push_back({32'hC0, 32'h0000_000C});
    release_rst();
    run_to_halt(100);
    check_read("cf", 0, 32'h00, 2);
    check_read("cf", 1, 32'h02, 5);
    check_read("cf", 2, 32'h10, 8);
    check_read("cf", 3, 32'h03, 11);
    check_read("cf", 4, 32'h04, 15);
    check_writes("cf");
    check("cf_instret", 64'(instret), 64'd4);
    check("cf_pc", 64'(pc_o), 64'h14);

    // Signed compare, lui, $0 writes, subu/and, beq not taken
    begin_test();
    put(32'h00, 32'h2401_FFFF);
    put(32'h04, 32'h0020_102A);
    put(32'h08, 32'h3C03_8000);
    put(32'h0C, 32'h0021_0021);
    put(32'h10, 32'h0062_2023);
    put(32'h14, 32'h0023_2824);
    put(32'h18, 32'h1020_0001);
    put(32'h1C, 32'hAC02_0100);
    put(32'h20, 32'hAC03_0104);
    put(32'h24, 32'hAC00_0108);
    put(32'h28, 32'hAC01_010C);
    put(32'h2C, 32'hAC04_0110);
    put(32'h30, 32'hAC05_0114);
    put(32'h34, 32'hFC00_0000);
    exp_q.push_back({32'h40, 32'h0000_0001});
    exp_q.push_back({32'h41, 32'h8000_0000});
    exp_q.push_back({32'h42, 32'h0000_0000});
    exp_q.push_back({32'h43, 32'hFFFF_FFFF});
    exp_q.push_back({32'h44, 32'h7FFF_FFFF});
    exp_q.push_back({32'h45, 32'h8000_0000});
    release_rst();
    run_to_halt(200);
    check_writes("alu");
    check("alu_instret", 64'(instret), 64'd13);

    // Illegal op at 0x4, then reset out of HALT
    begin_test();
    put(32'h00, 32'h3401_0005);
    put(32'h04, 32'hFC00_0000);
    release_rst();
    run_to_halt(50);
    repeat (20) @(negedge clk);
    #1;
    check("hlt_halted", 64'(halted), 64'd1);
    check("hlt_req", 64'(mem_req), 64'd0);
    check("hlt_instret", 64'(instret), 64'd1);
    check("hlt_state", 64'(dbg_state), 64'd6);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("hrst_halted", 64'(halted), 64'd0);
    check("hrst_instret", 64'(instret), 64'd0);
    check("hrst_pc", 64'(pc_o), 64'd0);
    rd_addr_q.delete();
    rd_cyc_q.delete();
    release_rst();
    run_to_halt(50);
    check_read("hrst", 0, 32'h00, 2);
    check("hrst_instret2", 64'(instret), 64'd1);

    // Reset in the middle of a waiting store: no write may land
    begin_test();
    put(32'h00, 32'hAC00_0100);
    put(32'h04, 32'hFC00_0000);
    mem[32'h40] = 32'h5555_AAAA;
    wait_addr = 10'h040;
    wait_n    = 10;
    release_rst();
    begin
      int n;
      n = 0;
      while (!(mem_req && mem_we) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("mrst_store_seen", 64'(mem_we), 64'd1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_req", 64'(mem_req), 64'd0);
    check("mrst_we", 64'(mem_we), 64'd0);
    check("mrst_state", 64'(dbg_state), 64'd0);
    wait_n = 0;
    repeat (3) @(negedge clk);
    check("mrst_no_write", 64'(wr_q.size()), 64'd0);
    check("mrst_mem", 64'(mem[32'h40]), 64'h5555_AAAA);
    exp_q.push_back({32'h40, 32'h0});
    release_rst();
    run_to_halt(50);
    check_writes("mrst");
    check("mrst_instret", 64'(instret), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
